// File: rtl/host_mem_responder_if.sv
// ============================================================================
// Module   : host_mem_responder_if
// Purpose  : Request/response bundle between an initiator and host_mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface host_mem_responder_if #(
    parameter int LINE_SIZE = 512
);
    logic [1:0]           op;
    logic [31:0]          io_addr;
    logic [LINE_SIZE-1:0] common_data_bus_out;
    logic [63:0]          cv_value;
    logic [LINE_SIZE-1:0] common_data_bus_in;
    logic                 rd_valid;
    logic                 tx_done;
    logic [63:0]          last_cv;
    logic                 err;

    modport master (
        output op, io_addr, common_data_bus_out, cv_value,
        input  common_data_bus_in, rd_valid, tx_done, last_cv, err
    );

    modport slave (
        input  op, io_addr, common_data_bus_out, cv_value,
        output common_data_bus_in, rd_valid, tx_done, last_cv, err
    );
endinterface

`default_nettype wire

// File: rtl/host_mem_responder.sv
// ============================================================================
// Module   : host_mem_responder
// Purpose  : Single-outstanding, fixed-latency cache-line memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module host_mem_responder #(
    parameter int LINE_SIZE   = 512,
    parameter int DEPTH_LINES = 64,
    parameter int RD_LATENCY  = 4,
    parameter int WR_LATENCY  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    host_mem_responder_if.slave    bus
);

    localparam int         c_idxW   = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam logic [3:0] c_rdLoad = 4'(RD_LATENCY - 1);
    localparam logic [3:0] c_wrLoad = 4'(WR_LATENCY - 1);
    localparam logic [1:0] c_opRead = 2'b01;
    localparam logic [1:0] c_opWrite = 2'b10;
    localparam logic [1:0] c_opRsvd = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_RESP = 3'd2,
        S_WR_WAIT = 3'd3,
        S_WR_DONE = 3'd4,
        S_TURN    = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [3:0]           r_count;
    logic [3:0]           w_countNext;
    logic                 w_accept;
    logic [c_idxW-1:0]    w_lineIdx;
    logic [c_idxW-1:0]    r_lineIdx;
    logic [LINE_SIZE-1:0] r_data;
    logic [63:0]          r_cv;
    logic [LINE_SIZE-1:0] r_mem [DEPTH_LINES];
    logic                 r_rdValid;
    logic                 r_txDone;
    logic [LINE_SIZE-1:0] r_rdData;
    logic [63:0]          r_lastCv;
    logic                 r_err;
    logic                 w_unusedAddr;

    // Upper bits alias onto the array; the byte offset within a line is irrelevant.
    assign w_lineIdx    = bus.io_addr[6 +: c_idxW];
    assign w_unusedAddr = ^{bus.io_addr[31:6+c_idxW], bus.io_addr[5:0]};
    assign w_accept     = (r_state == S_IDLE) && ((bus.op == c_opRead) || (bus.op == c_opWrite));

    always_comb begin
        w_nextState = r_state;
        w_countNext = r_count;
        case (r_state)
            S_IDLE: begin
                if (bus.op == c_opRead) begin
                    w_nextState = S_RD_WAIT;
                    w_countNext = c_rdLoad;
                end else if (bus.op == c_opWrite) begin
                    w_nextState = S_WR_WAIT;
                    w_countNext = c_wrLoad;
                end
            end
            S_RD_WAIT: begin
                if (r_count == 4'd0) w_nextState = S_RD_RESP;
                else                 w_countNext = r_count - 4'd1;
            end
            S_WR_WAIT: begin
                if (r_count == 4'd0) w_nextState = S_WR_DONE;
                else                 w_countNext = r_count - 4'd1;
            end
            S_RD_RESP, S_WR_DONE: w_nextState = S_TURN;
            S_TURN:               w_nextState = S_IDLE;
            default:              w_nextState = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they are registered yet
    // coincide with the response state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_count   <= 4'd0;
            r_rdValid <= 1'b0;
            r_txDone  <= 1'b0;
            r_rdData  <= '0;
            r_lastCv  <= 64'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_count   <= w_countNext;
            r_rdValid <= (w_nextState == S_RD_RESP);
            r_txDone  <= (w_nextState == S_RD_RESP) || (w_nextState == S_WR_DONE);
            r_rdData  <= (w_nextState == S_RD_RESP) ? r_data : '0;
            if ((w_nextState == S_RD_RESP) || (w_nextState == S_WR_DONE))
                r_lastCv <= r_cv;
            if ((r_state == S_IDLE) && (bus.op == c_opRsvd))
                r_err <= 1'b1;
        end
    end

    // For reads the line is snapshotted at acceptance into the same data register.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lineIdx <= w_lineIdx;
            r_cv      <= bus.cv_value;
            r_data    <= (bus.op == c_opWrite) ? bus.common_data_bus_out : r_mem[w_lineIdx];
        end
    end

    // Commit only while running; an async reset forces IDLE so no commit follows.
    always_ff @(posedge clk) begin
        if ((r_state == S_WR_WAIT) && (r_count == 4'd0))
            r_mem[r_lineIdx] <= r_data;
    end

    assign bus.common_data_bus_in = r_rdData;
    assign bus.rd_valid           = r_rdValid;
    assign bus.tx_done            = r_txDone;
    assign bus.last_cv            = r_lastCv;
    assign bus.err                = r_err;

endmodule

`default_nettype wire
